// File: rtl/ram_arb_pkg.sv
// Shared constants and helpers for the RAM arbiter slice.
package ram_arb_pkg;

  localparam int DEF_NUM_REQ             = 2;
  localparam int DEF_MEM_ADDR_WIDTH      = 7;
  localparam int DEF_MEM_DATA_WIDTH      = 32;
  localparam int DEF_MEM_DATA_SIZE_BYTES = 4;
  localparam int MAX_REQ                 = 8;

  // One-hot vector with bit idx set; all-zero when idx is out of range.
  function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx,
                                                input int unsigned num_req);
    logic [MAX_REQ-1:0] r;
    r = '0;
    if (idx < num_req) r = MAX_REQ'(1) << idx;
    return r;
  endfunction

endpackage

// File: rtl/ram.sv
// Single-port byte-enabled RAM with a registered (1-cycle) read port.
// A read issued in the same cycle as a write to the same word returns
// the old contents; the new value is visible from the next cycle on.
module ram #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int BYTES  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wen,
  input  logic [BYTES-1:0]  ben,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Byte-masked write into the array.
  always_ff @(posedge clk) begin
    if (wen) begin
      for (int b = 0; b < BYTES; b++) begin
        if (ben[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Registered read data, cleared while in reset.
  always_ff @(posedge clk) begin
    if (!reset_n) rdata <= '0;
    else          rdata <= mem[addr];
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last accepted
// requester, so every continuously-valid requester is served once per
// NUM_REQ cycles. A grant is always accepted (ready is the grant).
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  logic [IDX_W-1:0] last_grant;
  logic [IDX_W:0]   cand;

  // Rotating priority search starting at (last_grant + 1) mod NUM_REQ.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    grant_any    = 1'b0;
    cand         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, last_grant} + (IDX_W+1)'(i + 1);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!grant_any && req[cand[IDX_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[IDX_W-1:0];
      end
    end
    if (grant_any) grant_onehot[grant_idx] = 1'b1;
  end

  // Pointer moves only on acceptance; reset value gives requester 0 priority.
  always_ff @(posedge clk) begin
    if (reset)          last_grant <= IDX_W'(NUM_REQ - 1);
    else if (grant_any) last_grant <= grant_idx;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between NUM_REQ requesters.
// Handshake: a request is accepted in the cycle where i_req_valid[k] and
// o_req_ready[k] are both high; ready is the one-hot arbitration grant and
// never asserts for a non-valid requester. Each accepted operation yields
// exactly one o_rsp_valid pulse to its requester one cycle later, with no
// backpressure on the response side.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter  int NUM_REQ             = DEF_NUM_REQ,
  parameter  int MEM_ADDR_WIDTH      = DEF_MEM_ADDR_WIDTH,
  parameter  int MEM_DATA_WIDTH      = DEF_MEM_DATA_WIDTH,
  parameter  int MEM_DATA_SIZE_BYTES = DEF_MEM_DATA_SIZE_BYTES,
  localparam int IDX_W               = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_REQ-1:0]                     i_req_valid,
  output logic [NUM_REQ-1:0]                     o_req_ready,
  input  logic [NUM_REQ-1:0]                     i_req_wen,
  input  logic [NUM_REQ*MEM_ADDR_WIDTH-1:0]      i_req_addr,
  input  logic [NUM_REQ*MEM_DATA_SIZE_BYTES-1:0] i_req_ben,
  input  logic [NUM_REQ*MEM_DATA_WIDTH-1:0]      i_req_wdata,
  output logic [NUM_REQ-1:0]                     o_rsp_valid,
  output logic                                   o_rsp_is_read,
  output logic [MEM_DATA_WIDTH-1:0]              o_rsp_rdata,
  output logic                                   o_ram_reset_n,
  output logic [MEM_ADDR_WIDTH-1:0]              o_ram_addr,
  output logic                                   o_ram_wen,
  output logic [MEM_DATA_SIZE_BYTES-1:0]         o_ram_ben,
  output logic [MEM_DATA_WIDTH-1:0]              o_ram_wdata,
  input  logic [MEM_DATA_WIDTH-1:0]              i_ram_rdata
);

  logic [NUM_REQ-1:0] req_masked;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;
  int                 sel;

  logic               rsp_pend;
  logic [IDX_W-1:0]   rsp_id;
  logic               rsp_is_read;
  logic               rsp_live;

  // Requests seen during reset are never granted.
  assign req_masked    = i_req_valid & {NUM_REQ{~reset}};
  assign o_req_ready   = grant_onehot;
  assign o_ram_reset_n = ~reset;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .clk          (clk),
    .reset        (reset),
    .req          (req_masked),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .grant_any    (grant_any)
  );

  // Route the granted requester's command to the RAM; idle bus is all-zero.
  always_comb begin
    sel         = int'(grant_idx);
    o_ram_addr  = '0;
    o_ram_ben   = '0;
    o_ram_wdata = '0;
    o_ram_wen   = 1'b0;
    if (grant_any) begin
      o_ram_addr  = i_req_addr[sel*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
      o_ram_ben   = i_req_ben[sel*MEM_DATA_SIZE_BYTES +: MEM_DATA_SIZE_BYTES];
      o_ram_wdata = i_req_wdata[sel*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
      o_ram_wen   = i_req_wen[grant_idx];
    end
  end

  // Remember who was served so the RAM's registered read data can be
  // steered back one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_pend    <= 1'b0;
      rsp_id      <= '0;
      rsp_is_read <= 1'b0;
    end else begin
      rsp_pend <= grant_any;
      if (grant_any) begin
        rsp_id      <= grant_idx;
        rsp_is_read <= ~i_req_wen[grant_idx];
      end
    end
  end

  // A response pending when reset arrives is dropped, not delivered late.
  assign rsp_live = rsp_pend & ~reset;

  // Response strobe and data, forced to zero whenever nothing is live.
  always_comb begin
    o_rsp_valid   = '0;
    o_rsp_is_read = 1'b0;
    o_rsp_rdata   = '0;
    if (rsp_live) begin
      o_rsp_valid   = NUM_REQ'(onehot(int'(rsp_id), NUM_REQ));
      o_rsp_is_read = rsp_is_read;
      if (rsp_is_read) o_rsp_rdata = i_ram_rdata;
    end
  end

endmodule
